// File: rtl/pg_carry_lookahead_pipe.sv
// Two-stage speculative carry-lookahead over per-block group p/g.
// Optional error detection: define PG_CLA_ERR_DETECT_EN.
module pg_carry_lookahead_pipe #(
  parameter int NBLK = 4,
  parameter int LA   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBLK-1:0] in_p,
  input  logic [NBLK-1:0] in_g,
  input  logic            in_cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NBLK:0]   out_carry
`ifdef PG_CLA_ERR_DETECT_EN
  ,
  output logic            out_err,
  output logic [NBLK:0]   out_err_bits
`endif
);

  logic            s1_valid;
  logic [NBLK-1:0] s1_p;
  logic [NBLK-1:0] s1_g;
  logic            s1_cin;
  logic            s1_adv;
  logic            in_fire;
  logic [NBLK:0]   c_apx;
  logic [NBLK:0]   c_ext;

  assign s1_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_cin   <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_p     <= in_p;
      s1_g     <= in_g;
      s1_cin   <= in_cin;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Beyond the window, ripple from an assumed-zero carry at block i-LA.
  always_comb begin
    logic w;
    w        = 1'b0;
    c_ext    = '0;
    c_apx    = '0;
    c_ext[0] = s1_cin;
    c_apx[0] = s1_cin;
    for (int i = 1; i <= NBLK; i++) begin
      c_ext[i] = s1_g[i-1] | (s1_p[i-1] & c_ext[i-1]);
      w = 1'b0;
      for (int j = 0; j < NBLK; j++) begin
        if (j >= i - LA && j < i)
          w = s1_g[j] | (s1_p[j] & w);
      end
      c_apx[i] = (i <= LA) ? c_ext[i] : w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_carry    <= '0;
`ifdef PG_CLA_ERR_DETECT_EN
      out_err      <= 1'b0;
      out_err_bits <= '0;
`endif
    end else if (s1_adv) begin
      out_valid    <= 1'b1;
      out_carry    <= c_apx;
`ifdef PG_CLA_ERR_DETECT_EN
      out_err      <= |(c_apx ^ c_ext);
      out_err_bits <= c_apx ^ c_ext;
`endif
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pg_carry_lookahead_pipe.sv
// Directed bench: LA=2 and exact LA=4 instances in lockstep,
// scoreboard queue plus directed latency/handshake checks.
module tb_pg_carry_lookahead_pipe;

  localparam int N = 4;

  typedef struct {
    logic [N:0] apx;
    logic [N:0] ext;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [N-1:0] in_p;
  logic [N-1:0] in_g;
  logic         in_cin;
  logic         out_ready;
  logic         in_ready;
  logic         out_valid;
  logic [N:0]   out_carry;
  logic         in_ready_x;
  logic         out_valid_x;
  logic [N:0]   out_carry_x;

  int errors = 0;
  int checks = 0;
  exp_t q[$];

  pg_carry_lookahead_pipe #(.NBLK(N), .LA(2)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p(in_p), .in_g(in_g), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_carry(out_carry)
  );

  pg_carry_lookahead_pipe #(.NBLK(N), .LA(N)) u_exact (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_x),
    .in_p(in_p), .in_g(in_g), .in_cin(in_cin),
    .out_valid(out_valid_x), .out_ready(out_ready),
    .out_carry(out_carry_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [N:0] model(
    input logic [N-1:0] p,
    input logic [N-1:0] g,
    input logic         cin,
    input int           la
  );
    logic [N:0] c;
    logic t;
    c = '0;
    c[0] = cin;
    for (int i = 1; i <= N; i++) begin
      if (i <= la) begin
        c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end else begin
        for (int j = i - la; j < i; j++) begin
          t = g[j];
          for (int k = j + 1; k < i; k++) t = t & p[k];
          c[i] = c[i] | t;
        end
      end
    end
    return c;
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(
    input logic [N-1:0] p,
    input logic [N-1:0] g,
    input logic         cin
  );
    in_valid = 1'b1;
    in_p     = p;
    in_g     = g;
    in_cin   = cin;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("sb_unexpected", 32'(out_carry), 32'h1ff);
        end else begin
          e = q.pop_front();
          check("sb_la2", 32'(out_carry), 32'(e.apx));
          check("sb_la4", 32'(out_carry_x), 32'(e.ext));
          check("sb_vsync", 32'(out_valid_x), 32'd1);
        end
      end
      if (in_valid && in_ready) begin
        e.apx = model(in_p, in_g, in_cin, 2);
        e.ext = model(in_p, in_g, in_cin, N);
        q.push_back(e);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_p      = '0;
    in_g      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_oc", 32'(out_carry), 32'd0);
    check("rst_ir", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    drive(4'b1111, 4'b0000, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    check("fp_lat1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("fp_ov", 32'(out_valid), 32'd1);
    check("fp_c", 32'(out_carry), 32'b00111);
    check("fp_exact", 32'(out_carry_x), 32'b11111);

    drive(4'b1110, 4'b0001, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;
    check("gen_c", 32'(out_carry), 32'b00110);
    check("gen_exact", 32'(out_carry_x), 32'b11110);

    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(4'b0000, 4'b0001, 1'b0);
    @(posedge clk); #1 drive(4'b0000, 4'b0010, 1'b0);
    @(posedge clk); #1 drive(4'b0000, 4'b0100, 1'b0);
    check("bp_ir", 32'(in_ready), 32'd0);
    check("bp_hold", 32'(out_carry), 32'b00010);
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_ir", 32'(in_ready), 32'd0);
      check("bp_ov", 32'(out_valid), 32'd1);
      check("bp_hold", 32'(out_carry), 32'b00010);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    check("bp_2nd", 32'(out_carry), 32'b00100);
    @(posedge clk); #1;
    check("bp_3rd", 32'(out_carry), 32'b01000);
    @(posedge clk); #1;
    check("bp_empty", 32'(out_valid), 32'd0);

    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive(N'($urandom), N'($urandom), 1'($urandom));
      else in_valid = 1'b0;
      if (k < 8) check("tp_ir", 32'(in_ready), 32'd1);
      if (k >= 2) check("tp_ov", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    check("tp_end", 32'(out_valid), 32'd0);

    out_ready = 1'b0;
    drive(4'b1111, 4'b1010, 1'b1);
    @(posedge clk); #1 drive(4'b0110, 4'b0001, 1'b0);
    @(posedge clk); #1 in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mr_ov", 32'(out_valid), 32'd0);
    check("mr_oc", 32'(out_carry), 32'd0);
    check("mr_ir", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("mr_stale", 32'(out_valid), 32'd0);
    end
    drive(4'b0011, 4'b0100, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    check("mr_lat1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("mr_ov", 32'(out_valid), 32'd1);
    check("mr_c", 32'(out_carry), 32'b01111);
    repeat (3) @(posedge clk);
    #1 check("sb_drain", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pg_carry_lookahead_pipe.md
Name: pg_carry_lookahead_pipe

Overview:
- Consumer side of the group propagate/generate interface driven by the 3-bit ripple-carry PG slices.
- Takes per-block group (p, g) vectors plus the adder carry-in and resolves the carry into every block.
- The carry resolution is approximate: a bounded lookahead window, speculative-carry style.
- Two-stage pipeline with valid/ready handshakes on both sides. Sits between the slice array and the sum-correction/output register of the approximate adder datapath.

Parameters:
- NBLK, 4, number of PG slices (blocks) feeding the unit; legal range 2..16.
- LA, 2, lookahead window in blocks; legal range 1..NBLK. LA=NBLK gives exact carries.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  p/g/cin bundle valid.
- in_ready  output  1  unit accepts the bundle this cycle.
- in_p  input  NBLK  group propagate per block; bit i = block i (block 0 is least significant).
- in_g  input  NBLK  group generate per block.
- in_cin  input  1  carry into block 0.
- out_valid  output  1  out_carry valid.
- out_ready  input  1  downstream accepts out_carry.
- out_carry  output  NBLK+1  bit i = carry into block i; bit NBLK = carry-out.

Behaviour:
- Reset (rst=1 at a clock edge): both stage valid flags cleared, out_valid=0, out_carry=0, all data registers cleared. in_ready is 1 on the first cycle after reset.
- Reset mid-operation drops any in-flight bundles. No output for them is ever produced.
- Handshake:
  - Transfer occurs on a cycle with valid && ready.
  - in_ready = !s1_valid || s1_adv, where s1_adv = s1_valid && (!s2_valid || out_ready).
  - Stage 2 loads when s1_adv. It holds out_carry stable while out_valid && !out_ready.
  - in_ready does not depend combinationally on in_valid.
- Stage 1: registers in_p, in_g and in_cin on input transfer.
- Stage 2: computes carries from the stage-1 registers and registers them as out_carry.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput is 1 bundle per cycle with out_ready held high.
- Carry rules:
  - c[0] = cin.
  - For 1 <= i <= NBLK with i <= LA: exact, c[i] = g[i-1] | (p[i-1] & c[i-1]).
  - For i > LA: c[i] = OR over j = i-LA..i-1 of (g[j] & AND of p[j+1..i-1]). cin and blocks below i-LA are ignored, i.e. a propagate chain longer than LA is assumed to carry 0.
- Ordering: bundles leave in arrival order. No bundle is dropped or duplicated under any pattern of out_ready.
- Simultaneous events: input accept and output drain in the same cycle are legal, and the pipeline shifts.
- Undefined p/g encodings (p=1 and g=1 in the same block) are processed by the formula without special handling.

Optional Feature:
- Macro: PG_CLA_ERR_DETECT_EN.
- When defined:
  - Stage 2 also computes exact ripple carries from the same registers.
  - Adds output out_err (1 bit), set when the approximate and exact carry vectors differ.
  - Adds output out_err_bits (NBLK+1), the XOR of the approximate and exact carry vectors.
  - Both outputs are registered alongside out_carry, share the out_valid qualifier, and reset to 0.
- When undefined: these ports and that logic do not exist. The port list is exactly as above.

Test Plan (NBLK=4, LA=2 unless noted):
- Full propagate: p=1111, g=0000, cin=1, out_ready=1 -> out_carry=5'b00111 two cycles after accept. With PG_CLA_ERR_DETECT_EN: out_err=1, out_err_bits=5'b11000.
- Long generate chain: p=1110, g=0001, cin=0 -> out_carry=5'b00110. Exact would be 5'b11110, so out_err_bits=5'b11000.
- Exact config (LA=4): p=1111, g=0000, cin=1 -> out_carry=5'b11111; out_err=0.
- Backpressure:
  - Stimulus: three back-to-back bundles (g=0001, 0010, 0100; p=0; cin=0), out_ready=0 for 5 cycles.
  - in_ready goes low after 2 accepts and out_carry holds 5'b00010.
  - On release, outputs appear in order: 00010, 00100, 01000.
- Throughput: 8 consecutive bundles with in_valid=1 and out_ready=1 -> in_ready stays 1 and out_valid stays 1 for 8 consecutive cycles starting 2 cycles after the first accept.
- Reset mid-flight: accept 2 bundles, assert rst for 1 cycle -> out_valid=0 and out_carry=0 the next cycle, and no stale bundle ever emerges. A new bundle after reset appears with latency 2.
